// File: rtl/pll_drp_reconfig_ctrl.sv
// pll_drp_reconfig_ctrl
//   Run-time reprogramming sequencer for a DRP-enabled MMCM/PLL, clocked from
//   the stable clk10 domain. On a request it holds the target PLL in reset,
//   read-modify-writes every DRP entry of the selected preset, then releases
//   reset and waits for lock. Presets live in an external combinational ROM.
//   Optional feature macro: LOCK_MONITOR_EN (builds the sticky lock_lost
//   monitor; without it lock_lost is tied to 0).
module pll_drp_reconfig_ctrl #(
  parameter int NUM_CFG      = 4,
  parameter int N_REGS       = 8,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 1000,
  parameter int RST_HOLD     = 4
) (
  input  logic                              clk10,
  input  logic                              rst,
  input  logic                              cfg_req,
  input  logic [$clog2(NUM_CFG)-1:0]        cfg_sel,
  output logic                              cfg_busy,
  output logic                              cfg_done,
  output logic                              cfg_err,
  output logic [$clog2(NUM_CFG*N_REGS)-1:0] rom_addr,
  input  logic [38:0]                       rom_data,
  output logic                              drp_den,
  output logic                              drp_dwe,
  output logic [6:0]                        drp_daddr,
  output logic [15:0]                       drp_di,
  input  logic [15:0]                       drp_do,
  input  logic                              drp_drdy,
  output logic                              pll_rst,
  input  logic                              pll_locked,
  output logic                              lock_lost
);

  localparam int SW   = $clog2(NUM_CFG);
  localparam int AW   = $clog2(NUM_CFG * N_REGS);
  localparam int IW   = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int TMAX = (LOCK_TIMEOUT > DRDY_TIMEOUT)
                      ? ((LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD)
                      : ((DRDY_TIMEOUT > RST_HOLD) ? DRDY_TIMEOUT : RST_HOLD);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] HOLD_LAST = TW'(RST_HOLD - 1);
  localparam logic [TW-1:0] DRDY_LAST = TW'(DRDY_TIMEOUT - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_REGS - 1);
  localparam logic [AW-1:0] NREGS_A   = AW'(N_REGS);
  localparam logic [31:0]   NUM_CFG_U = 32'(NUM_CFG);

  typedef enum logic [3:0] {
    S_IDLE, S_HOLD, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT,
    S_NEXT, S_RELEASE, S_LOCK_WAIT, S_DONE, S_ERROR
  } state_t;

  state_t          state_q;
  logic [SW-1:0]   sel_q;
  logic [IW-1:0]   idx_q;
  logic [TW-1:0]   timer_q;
  logic [TW-1:0]   timer_d;
  logic            busy_q, done_q, err_q;
  logic            den_q, dwe_q, pll_rst_q;
  logic [15:0]     di_q;
  logic            lock_meta_q, lock_sync_q;
  logic [31:0]     sel_ext;

  logic [6:0]      rom_daddr;
  logic [15:0]     rom_mask, rom_wdata;

  assign rom_daddr = rom_data[38:32];
  assign rom_mask  = rom_data[31:16];
  assign rom_wdata = rom_data[15:0];
  assign sel_ext   = 32'(cfg_sel);

  // Per-state cycle counter; holds at all-ones instead of wrapping.
  assign timer_d = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;

  // ROM index of the entry currently being processed.
  assign rom_addr = AW'(sel_q) * NREGS_A + AW'(idx_q);

  assign cfg_busy  = busy_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign drp_den   = den_q;
  assign drp_dwe   = dwe_q;
  // The ROM entry is stable for the whole RD/WR cycle, so the address follows it directly.
  assign drp_daddr = den_q ? rom_daddr : 7'd0;
  assign drp_di    = di_q;
  assign pll_rst   = pll_rst_q;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge clk10 or posedge rst) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= pll_locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  // Reconfiguration sequencer with registered outputs.
  always_ff @(posedge clk10 or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      pll_rst_q <= 1'b0;
      di_q      <= '0;
    end else begin
      timer_q <= timer_d;
      den_q   <= 1'b0;
      dwe_q   <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_req) begin
            busy_q  <= 1'b1;
            idx_q   <= '0;
            timer_q <= '0;
            if (sel_ext >= NUM_CFG_U) begin
              err_q   <= 1'b1;
              state_q <= S_ERROR;
            end else begin
              err_q     <= 1'b0;
              sel_q     <= cfg_sel;
              pll_rst_q <= 1'b1;
              state_q   <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (timer_q == HOLD_LAST) begin
            den_q   <= 1'b1;
            timer_q <= '0;
            state_q <= S_RD;
          end
        end
        S_RD: begin
          timer_q <= '0;
          state_q <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (drp_drdy) begin
            // Mask bits set keep the current register contents.
            di_q    <= (drp_do & rom_mask) | (rom_wdata & ~rom_mask);
            den_q   <= 1'b1;
            dwe_q   <= 1'b1;
            timer_q <= '0;
            state_q <= S_WR;
          end else if (timer_q == DRDY_LAST) begin
            err_q   <= 1'b1;
            timer_q <= '0;
            state_q <= S_ERROR;
          end
        end
        S_WR: begin
          timer_q <= '0;
          state_q <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (drp_drdy) begin
            timer_q <= '0;
            state_q <= S_NEXT;
          end else if (timer_q == DRDY_LAST) begin
            err_q   <= 1'b1;
            timer_q <= '0;
            state_q <= S_ERROR;
          end
        end
        S_NEXT: begin
          timer_q <= '0;
          if (idx_q == IDX_LAST) begin
            pll_rst_q <= 1'b0;
            state_q   <= S_RELEASE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            den_q   <= 1'b1;
            state_q <= S_RD;
          end
        end
        S_RELEASE: begin
          timer_q <= '0;
          state_q <= S_LOCK_WAIT;
        end
        S_LOCK_WAIT: begin
          if (lock_sync_q) begin
            done_q  <= 1'b1;
            timer_q <= '0;
            state_q <= S_DONE;
          end else if (timer_q == LOCK_LAST) begin
            err_q   <= 1'b1;
            timer_q <= '0;
            state_q <= S_ERROR;
          end
        end
        S_DONE, S_ERROR: begin
          // pll_rst is left as-is: still high after a DRP timeout, already low after a lock timeout.
          busy_q  <= 1'b0;
          timer_q <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          timer_q <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LOCK_MONITOR_EN
  logic armed_q;
  logic lost_q;

  // Arm after a successful configuration; flag any synced-lock drop seen while idle.
  always_ff @(posedge clk10 or posedge rst) begin
    if (rst) begin
      armed_q <= 1'b0;
      lost_q  <= 1'b0;
    end else if (state_q == S_IDLE && cfg_req) begin
      armed_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      if (state_q == S_DONE) begin
        armed_q <= 1'b1;
      end
      if (state_q == S_IDLE && armed_q && !lock_sync_q) begin
        lost_q <= 1'b1;
      end
    end
  end

  assign lock_lost = lost_q;
`else
  assign lock_lost = 1'b0;
`endif

endmodule
